// File: rtl/mig7_traffic_pkg.sv
// Shared types and constants for the MIG7 traffic generator.
// Holds FSM states, MIG command codes and the LFSR definition.
package mig7_traffic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL,
    S_WR,
    S_RD,
    S_DRAIN,
    S_FIN
  } state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic [1:0] MODE_WR   = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WRRD = 2'b10;
  localparam logic [1:0] MODE_LOOP = 2'b11;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // Right-shifting Galois LFSR: taps applied when the shifted-out bit is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/mig7_traffic_pattern_gen.sv
// Beat address and data generator, shared by the issue and check sides.
// init reloads base/seed; step advances one beat.
module mig7_pattern_gen
  import mig7_traffic_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int ADDR_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic              pattern,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       lane;

  always_comb begin
    addr_d = addr_q;
    lfsr_d = lfsr_q;
    if (init) begin
      addr_d = base_addr;
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(ADDR_STEP);
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      lfsr_q <= '0;
    end else begin
      addr_q <= addr_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign lane = pattern ? lfsr_q : 32'(addr_q);
  assign addr = addr_q;
  assign data = {(DATA_W/32){lane}};

endmodule

// File: rtl/mig7_traffic.sv
// MIG7 user-interface traffic generator: write, read-check and loop modes.
// Reads are checked in order against an independent pattern generator.
module mig7_traffic
  import mig7_traffic_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic                pattern,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [31:0]         err_cnt,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [15:0]         loops,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic                init_calib_complete,
  output logic                app_sr_req,
  output logic                app_ref_req,
  output logic                app_zq_req
);

  localparam int CW = LEN_W + 1;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              pattern_q, pattern_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     ret_q, ret_d;
  logic              cmd_done_q, cmd_done_d;
  logic              dat_done_q, dat_done_d;
  logic              stop_q, stop_d;
  logic              pass_q, pass_d;
  logic [15:0]       loops_q, loops_d;
  logic [31:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic              cmp_bad_q, cmp_bad_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;

  logic              iss_init, iss_step;
  logic              chk_init, chk_step;
  logic [ADDR_W-1:0] iss_addr, chk_addr;
  logic [DATA_W-1:0] iss_data, chk_data;
  logic              go, cmd_acc, dat_acc;
  logic              cmd_now, dat_now;
  logic              rd_vld, loop_again;

  mig7_pattern_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ADDR_STEP (ADDR_STEP)
  ) u_iss_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (iss_init),
    .step      (iss_step),
    .pattern   (pattern_q),
    .base_addr (base_q),
    .addr      (iss_addr),
    .data      (iss_data)
  );

  mig7_pattern_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ADDR_STEP (ADDR_STEP)
  ) u_chk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (chk_init),
    .step      (chk_step),
    .pattern   (pattern_q),
    .base_addr (base_q),
    .addr      (chk_addr),
    .data      (chk_data)
  );

  // A pending stop blocks only the start of a fresh write beat.
  assign go = ~stop_q | cmd_done_q | dat_done_q;

  assign app_en = ((state_q == S_WR) && !cmd_done_q && go) ||
                  ((state_q == S_RD) && !stop_q);
  assign app_wdf_wren = (state_q == S_WR) && !dat_done_q && go;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign app_cmd      = (state_q == S_RD) ? CMD_RD : CMD_WR;
  assign app_addr     = iss_addr;
  assign app_wdf_data = iss_data;
  assign app_sr_req   = 1'b0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;

  assign cmd_acc = app_en & app_rdy;
  assign dat_acc = app_wdf_wren & app_wdf_rdy;
  assign cmd_now = cmd_done_q | cmd_acc;
  assign dat_now = dat_done_q | dat_acc;
  assign rd_vld  = app_rd_data_valid &&
                   ((state_q == S_RD) || (state_q == S_DRAIN));
  assign chk_step = rd_vld;

  assign loop_again = (state_q == S_FIN) && (mode_q == MODE_LOOP) && !stop_q;
  assign done     = (state_q == S_FIN) && !loop_again;
  assign busy     = (state_q != S_IDLE) && !done;
  assign pass     = done ? (err_cnt_q == '0) : pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign loops    = loops_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pattern_d  = pattern_q;
    base_d     = base_q;
    len_d      = len_q;
    iss_d      = iss_q;
    ret_d      = ret_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    stop_d     = stop_q | (stop && (state_q != S_IDLE));
    pass_d     = pass_q;
    loops_d    = loops_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    iss_init   = 1'b0;
    iss_step   = 1'b0;
    chk_init   = 1'b0;

    cmp_vld_d  = rd_vld;
    cmp_bad_d  = app_rd_data != chk_data;
    cmp_addr_d = chk_addr;
    if (rd_vld) ret_d = ret_q + CW'(1);
    if (cmp_vld_q && cmp_bad_q) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
      if (err_cnt_q == '0) err_addr_d = cmp_addr_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          pattern_d  = pattern;
          base_d     = base_addr;
          len_d      = (length == '0) ? (CW'(1) << LEN_W) : CW'(length);
          err_cnt_d  = '0;
          err_addr_d = '0;
          loops_d    = '0;
          stop_d     = 1'b0;
          pass_d     = 1'b0;
          state_d    = S_CAL;
        end
      end
      S_CAL: begin
        if (stop_q) begin
          state_d = S_FIN;
        end else if (init_calib_complete) begin
          iss_init   = 1'b1;
          chk_init   = 1'b1;
          iss_d      = '0;
          ret_d      = '0;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          state_d    = (mode_q == MODE_RD) ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (cmd_now && dat_now) begin
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          iss_step   = 1'b1;
          iss_d      = iss_q + CW'(1);
          if (iss_q + CW'(1) == len_q) begin
            iss_d    = '0;
            iss_init = 1'b1;
            state_d  = (mode_q == MODE_WR) ? S_FIN : S_RD;
          end
        end else if (stop_q && !cmd_done_q && !dat_done_q) begin
          state_d = S_FIN;
        end else begin
          cmd_done_d = cmd_now;
          dat_done_d = dat_now;
        end
      end
      S_RD: begin
        if (stop_q) begin
          state_d = S_DRAIN;
        end else if (cmd_acc) begin
          iss_step = 1'b1;
          iss_d    = iss_q + CW'(1);
          if (iss_q + CW'(1) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_q == iss_q) state_d = S_FIN;
      end
      S_FIN: begin
        if (loop_again) begin
          loops_d    = loops_q + 16'd1;
          iss_init   = 1'b1;
          chk_init   = 1'b1;
          iss_d      = '0;
          ret_d      = '0;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          state_d    = S_WR;
        end else begin
          pass_d  = (err_cnt_q == '0);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      pattern_q  <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      iss_q      <= '0;
      ret_q      <= '0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
      stop_q     <= 1'b0;
      pass_q     <= 1'b0;
      loops_q    <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_bad_q  <= 1'b0;
      cmp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pattern_q  <= pattern_d;
      base_q     <= base_d;
      len_q      <= len_d;
      iss_q      <= iss_d;
      ret_q      <= ret_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
      stop_q     <= stop_d;
      pass_q     <= pass_d;
      loops_q    <= loops_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_bad_q  <= cmp_bad_d;
      cmp_addr_q <= cmp_addr_d;
    end
  end

endmodule

// File: tb/tb_mig7_traffic.sv
// Testbench for mig7_traffic: MIG memory model plus directed and random runs.
// Expected addresses/data come from base + k*step and a stepped LFSR.
module tb_mig7_traffic;

  localparam int ADDR_W    = 28;
  localparam int DATA_W    = 128;
  localparam int LEN_W     = 8;
  localparam int ADDR_STEP = 8;

  logic                clk;
  logic                rst_n;
  logic                start, stop;
  logic [1:0]          mode;
  logic                pattern;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    length;
  logic                busy, done, pass;
  logic [31:0]         err_cnt;
  logic [ADDR_W-1:0]   err_addr;
  logic [15:0]         loops;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_wren;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;
  logic                app_rdy, app_wdf_rdy;
  logic                init_calib_complete;
  logic                app_sr_req, app_ref_req, app_zq_req;

  mig7_traffic #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .ADDR_STEP (ADDR_STEP)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .stop                (stop),
    .mode                (mode),
    .pattern             (pattern),
    .base_addr           (base_addr),
    .length              (length),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .err_cnt             (err_cnt),
    .err_addr            (err_addr),
    .loops               (loops),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .init_calib_complete (init_calib_complete),
    .app_sr_req          (app_sr_req),
    .app_ref_req         (app_ref_req),
    .app_zq_req          (app_zq_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model state.
  int rdy_mode = 0;
  int cyc = 0;
  int wcnt = 0;
  int rq_last = 0;
  int done_cnt = 0;
  logic corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  logic [ADDR_W-1:0] pend_a[$];
  logic [DATA_W-1:0] pend_d[$];
  logic [ADDR_W-1:0] rq_addr[$];
  int                rq_time[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] b,
                                                 input int k);
    logic [63:0] x;
    x = 64'(b) + 64'(k) * 64'(ADDR_STEP);
    return x[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic p,
                                                 input logic [ADDR_W-1:0] b,
                                                 input int k);
    logic [31:0] lane;
    if (p) begin
      lane = 32'hACE1_0001;
      for (int i = 0; i < k; i++)
        lane = (lane >> 1) ^ (lane[0] ? 32'h8020_0003 : 32'h0);
    end else begin
      lane = 32'(exp_addr(b, k));
    end
    return {(DATA_W/32){lane}};
  endfunction

  // MIG model: ready generation, transaction logging, in-order read returns.
  initial begin
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0: app_rdy = 1'b1;
        1: app_rdy = (cyc % 2) == 0;
        2: app_rdy = 1'($urandom_range(0, 1));
        default: app_rdy = 1'b0;
      endcase
      case (rdy_mode)
        0: app_wdf_rdy = 1'b1;
        1: begin
          if (app_wdf_wren) begin
            app_wdf_rdy = (wcnt >= 3);
            wcnt = app_wdf_rdy ? 0 : wcnt + 1;
          end else begin
            app_wdf_rdy = 1'b0;
            wcnt = 0;
          end
        end
        2: app_wdf_rdy = 1'($urandom_range(0, 1));
        default: app_wdf_rdy = 1'b0;
      endcase
      if (rst_n) begin
        if (app_en && app_rdy) begin
          if (app_cmd == 3'b000) begin
            wr_addr_log.push_back(app_addr);
            pend_a.push_back(app_addr);
          end else if (app_cmd == 3'b001) begin
            int t;
            rd_addr_log.push_back(app_addr);
            t = cyc + int'($urandom_range(2, 6));
            if (t <= rq_last) t = rq_last + 1;
            rq_last = t;
            rq_addr.push_back(app_addr);
            rq_time.push_back(t);
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          wr_data_log.push_back(app_wdf_data);
          pend_d.push_back(app_wdf_data);
        end
        while (pend_a.size() > 0 && pend_d.size() > 0)
          mem[pend_a.pop_front()] = pend_d.pop_front();
        if (done) done_cnt++;
      end
      app_rd_data_valid = 1'b0;
      if (rq_addr.size() > 0 && rq_time[0] <= cyc) begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        a = rq_addr.pop_front();
        void'(rq_time.pop_front());
        d = mem.exists(a) ? mem[a] : '0;
        if (corrupt_en && a == corrupt_addr) d = d ^ DATA_W'(1);
        app_rd_data = d;
        app_rd_data_valid = 1'b1;
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic p,
                           input logic [ADDR_W-1:0] b,
                           input logic [LEN_W-1:0] l);
    @(negedge clk);
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_addr_log.delete();
    done_cnt = 0;
    mode = m;
    pattern = p;
    base_addr = b;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    logic got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    check("busy_at_done", busy, 1'b0);
  endtask

  task automatic settle_one_done();
    repeat (3) @(negedge clk);
    check("single_done", done_cnt, 1);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic check_lists(input logic p, input logic [ADDR_W-1:0] b,
                             input int n, input bit do_wr, input bit do_rd);
    if (do_wr) begin
      check("wr_cmd_count", wr_addr_log.size(), n);
      check("wr_dat_count", wr_data_log.size(), n);
      for (int k = 0; k < n; k++) begin
        check($sformatf("wr_addr[%0d]", k),
              k < wr_addr_log.size() ? wr_addr_log[k] : 'x, exp_addr(b, k));
        check($sformatf("wr_data[%0d]", k),
              k < wr_data_log.size() ? wr_data_log[k] : 'x, exp_data(p, b, k));
      end
    end
    if (do_rd) begin
      check("rd_cmd_count", rd_addr_log.size(), n);
      for (int k = 0; k < n; k++)
        check($sformatf("rd_addr[%0d]", k),
              k < rd_addr_log.size() ? rd_addr_log[k] : 'x, exp_addr(b, k));
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] b;
    logic p;
    int l;
    logic reached;

    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mode = '0;
    pattern = 1'b0;
    base_addr = '0;
    length = '0;
    init_calib_complete = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_cnt", err_cnt, 32'h0);
    check("rst_loops", loops, 16'h0);
    check("rst_app_addr", app_addr, '0);
    check("rst_wdf_data", app_wdf_data, '0);
    check("tie_reqs", {app_sr_req, app_ref_req, app_zq_req}, 3'b000);
    rst_n = 1'b1;

    // Mode 10, address pattern, base 0x100, 4 beats; calibration late.
    rdy_mode = 0;
    start_run(2'b10, 1'b0, 28'h100, 8'd4);
    repeat (5) @(negedge clk);
    check("cal_busy", busy, 1'b1);
    check("cal_no_en", app_en, 1'b0);
    init_calib_complete = 1'b1;
    wait_done(200);
    check("t1_pass", pass, 1'b1);
    check("t1_err_cnt", err_cnt, 32'h0);
    settle_one_done();
    check_lists(1'b0, 28'h100, 4, 1'b1, 1'b1);
    check("t1_last_addr", wr_addr_log.size() == 4 ? wr_addr_log[3] : 'x, 28'h118);
    check("t1_mask", app_wdf_mask, '0);

    // Same run with throttled command and data ready.
    rdy_mode = 1;
    start_run(2'b10, 1'b0, 28'h100, 8'd4);
    wait_done(400);
    check("t2_pass", pass, 1'b1);
    settle_one_done();
    check_lists(1'b0, 28'h100, 4, 1'b1, 1'b1);

    // LFSR write, then read-check with beat 5 corrupted.
    rdy_mode = 2;
    b = ADDR_W'($urandom) & ~ADDR_W'(7);
    start_run(2'b00, 1'b1, b, 8'd8);
    wait_done(500);
    check("t3w_pass", pass, 1'b1);
    settle_one_done();
    check_lists(1'b1, b, 8, 1'b1, 1'b0);
    corrupt_en = 1'b1;
    corrupt_addr = exp_addr(b, 5);
    start_run(2'b01, 1'b1, b, 8'd8);
    wait_done(500);
    check("t3r_err_cnt", err_cnt, 32'd1);
    check("t3r_err_addr", err_addr, exp_addr(b, 5));
    check("t3r_pass", pass, 1'b0);
    settle_one_done();
    check_lists(1'b1, b, 8, 1'b0, 1'b1);
    corrupt_en = 1'b0;

    // Address wrap at the top of the address space.
    start_run(2'b10, 1'b0, 28'hFFFFFF8, 8'd3);
    wait_done(500);
    check("t4_pass", pass, 1'b1);
    settle_one_done();
    check("t4_addr1", wr_addr_log.size() == 3 ? wr_addr_log[1] : 'x, 28'h0);
    check("t4_addr2", wr_addr_log.size() == 3 ? wr_addr_log[2] : 'x, 28'h8);
    check_lists(1'b0, 28'hFFFFFF8, 3, 1'b1, 1'b1);

    // Randomised write/read-check runs.
    repeat (4) begin
      p = 1'($urandom_range(0, 1));
      b = ADDR_W'($urandom) & ~ADDR_W'(7);
      l = int'($urandom_range(1, 24));
      start_run(2'b10, p, b, LEN_W'(l));
      wait_done(1000);
      check("rnd_pass", pass, 1'b1);
      check("rnd_err_cnt", err_cnt, 32'h0);
      settle_one_done();
      check_lists(p, b, l, 1'b1, 1'b1);
    end

    // length 0 means the full 2^LEN_W beats.
    rdy_mode = 0;
    b = 28'h0001000;
    start_run(2'b00, 1'b0, b, 8'd0);
    wait_done(2000);
    settle_one_done();
    check_lists(1'b0, b, 256, 1'b1, 1'b0);

    // Continuous mode stopped during the second pass's read phase.
    rdy_mode = 2;
    b = 28'h0002000;
    start_run(2'b11, 1'b0, b, 8'd16);
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (loops == 16'd1 && rd_addr_log.size() > 16) begin
        reached = 1'b1;
        break;
      end
    end
    check("t7_reached_loop2_rd", reached, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(500);
    check("t7_loops", loops, 16'd1);
    check("t7_drained", rq_addr.size(), 0);
    check("t7_pass", pass, 1'b1);
    check("t7_wr_count", wr_addr_log.size(), 32);
    check("t7_rd_cut", rd_addr_log.size() < 32, 1'b1);
    settle_one_done();

    // Reset in the middle of a stalled write.
    rdy_mode = 3;
    start_run(2'b00, 1'b0, 28'h200, 8'd50);
    repeat (4) @(negedge clk);
    check("t8_en_before_rst", app_en, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t8_app_en", app_en, 1'b0);
    check("t8_wren", app_wdf_wren, 1'b0);
    check("t8_wdf_end", app_wdf_end, 1'b0);
    check("t8_cmd", app_cmd, 3'b000);
    check("t8_addr", app_addr, '0);
    check("t8_data", app_wdf_data, '0);
    check("t8_busy", busy, 1'b0);
    check("t8_done", done, 1'b0);
    check("t8_pass", pass, 1'b0);
    check("t8_err_cnt", err_cnt, 32'h0);
    check("t8_err_addr", err_addr, '0);
    check("t8_loops", loops, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery run after the abort.
    rdy_mode = 0;
    start_run(2'b10, 1'b1, 28'h40, 8'd5);
    wait_done(500);
    check("t9_pass", pass, 1'b1);
    settle_one_done();
    check_lists(1'b1, 28'h40, 5, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
